// File: rtl/roi_window_mask.sv
// Region-of-interest stage: tracks pixel coordinates, evaluates N_WIN programmable windows
// and applies pass / mask / crop / border, with window config swapped only at frame start.
module roi_window_mask #(
  parameter int unsigned     P_W   = 12,
  parameter int unsigned     C_W   = 8,
  parameter int unsigned     IMG_W = 640,
  parameter int unsigned     IMG_H = 480,
  parameter int unsigned     N_WIN = 4,
  parameter logic [C_W-1:0]  BG_R  = '0,
  parameter logic [C_W-1:0]  BG_G  = '0,
  parameter logic [C_W-1:0]  BG_B  = '0,
  parameter logic [C_W-1:0]  BOX_R = '1,
  parameter logic [C_W-1:0]  BOX_G = '0,
  parameter logic [C_W-1:0]  BOX_B = '0,
  parameter int unsigned     I_W   = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             i_frame_start,
  input  logic             i_valid,
  input  logic [C_W-1:0]   i_R,
  input  logic [C_W-1:0]   i_G,
  input  logic [C_W-1:0]   i_B,
  input  logic             cfg_we,
  input  logic [I_W-1:0]   cfg_idx,
  input  logic             cfg_en,
  input  logic [P_W-1:0]   cfg_x1,
  input  logic [P_W-1:0]   cfg_x2,
  input  logic [P_W-1:0]   cfg_y1,
  input  logic [P_W-1:0]   cfg_y2,
  input  logic             cfg_mode_we,
  input  logic [1:0]       cfg_mode,
  output logic             o_valid,
  output logic [C_W-1:0]   o_R,
  output logic [C_W-1:0]   o_G,
  output logic [C_W-1:0]   o_B,
  output logic [P_W-1:0]   o_x,
  output logic [P_W-1:0]   o_y,
  output logic [N_WIN-1:0] o_hit,
  output logic             o_eof
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_MASK   = 2'd1,
    MODE_CROP   = 2'd2,
    MODE_BORDER = 2'd3
  } mode_e;

  localparam logic [P_W-1:0] X_LAST = P_W'(IMG_W - 1);
  localparam logic [P_W-1:0] Y_LAST = P_W'(IMG_H - 1);

  logic [P_W-1:0] x_cnt, y_cnt, cur_x, cur_y;
  logic           commit, cfg_idx_ok;

  // Coordinate of the pixel presented this cycle; frame start forces (0,0).
  assign cur_x      = i_frame_start ? '0 : x_cnt;
  assign cur_y      = i_frame_start ? '0 : y_cnt;
  assign commit     = i_valid && (cur_x == '0) && (cur_y == '0);
  assign cfg_idx_ok = (32'(cfg_idx) < N_WIN);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (i_valid) begin
      if (cur_x == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + P_W'(1);
      end else begin
        x_cnt <= cur_x + P_W'(1);
        y_cnt <= cur_y;
      end
    end else if (i_frame_start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end
  end

  logic           pend_en [N_WIN];
  logic [P_W-1:0] pend_x1 [N_WIN];
  logic [P_W-1:0] pend_x2 [N_WIN];
  logic [P_W-1:0] pend_y1 [N_WIN];
  logic [P_W-1:0] pend_y2 [N_WIN];
  mode_e          pend_mode;
  logic           act_en  [N_WIN];
  logic [P_W-1:0] act_x1  [N_WIN];
  logic [P_W-1:0] act_x2  [N_WIN];
  logic [P_W-1:0] act_y1  [N_WIN];
  logic [P_W-1:0] act_y2  [N_WIN];
  mode_e          act_mode;

  // Pending bank: host writes land here at any time.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < N_WIN; i++) begin
        pend_en[i] <= 1'b0;
        pend_x1[i] <= '0;
        pend_x2[i] <= '0;
        pend_y1[i] <= '0;
        pend_y2[i] <= '0;
      end
      pend_mode <= MODE_PASS;
    end else begin
      if (cfg_we && cfg_idx_ok) begin
        pend_en[cfg_idx] <= cfg_en;
        pend_x1[cfg_idx] <= cfg_x1;
        pend_x2[cfg_idx] <= cfg_x2;
        pend_y1[cfg_idx] <= cfg_y1;
        pend_y2[cfg_idx] <= cfg_y2;
      end
      if (cfg_mode_we) pend_mode <= mode_e'(cfg_mode);
    end
  end

  // Active bank: copies the pre-write pending state as the (0,0) pixel enters stage 1.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < N_WIN; i++) begin
        act_en[i] <= 1'b0;
        act_x1[i] <= '0;
        act_x2[i] <= '0;
        act_y1[i] <= '0;
        act_y2[i] <= '0;
      end
      act_mode <= MODE_PASS;
    end else if (commit) begin
      for (int unsigned i = 0; i < N_WIN; i++) begin
        act_en[i] <= pend_en[i];
        act_x1[i] <= pend_x1[i];
        act_x2[i] <= pend_x2[i];
        act_y1[i] <= pend_y1[i];
        act_y2[i] <= pend_y2[i];
      end
      act_mode <= pend_mode;
    end
  end

  logic           s1_valid, s1_eof;
  logic [C_W-1:0] s1_r, s1_g, s1_b;
  logic [P_W-1:0] s1_x, s1_y;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_valid <= 1'b0;
      s1_eof   <= 1'b0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_eof <= (cur_x == X_LAST) && (cur_y == Y_LAST);
        s1_r   <= i_R;
        s1_g   <= i_G;
        s1_b   <= i_B;
        s1_x   <= cur_x;
        s1_y   <= cur_y;
      end
    end
  end

  logic [N_WIN-1:0] win_hit;
  logic             edge_any, keep;
  logic [C_W-1:0]   col_r, col_g, col_b;

  // Window compare; an inverted range can never satisfy both bounds, so it is empty.
  always_comb begin
    win_hit  = '0;
    edge_any = 1'b0;
    for (int unsigned i = 0; i < N_WIN; i++) begin
      if (act_en[i] && (s1_x >= act_x1[i]) && (s1_x <= act_x2[i]) &&
          (s1_y >= act_y1[i]) && (s1_y <= act_y2[i])) begin
        win_hit[i] = 1'b1;
        if ((s1_x == act_x1[i]) || (s1_x == act_x2[i]) ||
            (s1_y == act_y1[i]) || (s1_y == act_y2[i])) edge_any = 1'b1;
      end
    end
  end

  always_comb begin
    keep  = s1_valid;
    col_r = s1_r;
    col_g = s1_g;
    col_b = s1_b;
    case (act_mode)
      MODE_MASK: begin
        if (win_hit == '0) begin
          col_r = BG_R;
          col_g = BG_G;
          col_b = BG_B;
        end
      end
      MODE_CROP: keep = s1_valid && (win_hit != '0);
      MODE_BORDER: begin
        if (edge_any) begin
          col_r = BOX_R;
          col_g = BOX_G;
          col_b = BOX_B;
        end
      end
      default: ;
    endcase
  end

  // Output stage; dropped pixels leave colour, coordinates and hits unchanged.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      o_valid <= 1'b0;
      o_eof   <= 1'b0;
      o_R     <= '0;
      o_G     <= '0;
      o_B     <= '0;
      o_x     <= '0;
      o_y     <= '0;
      o_hit   <= '0;
    end else begin
      o_valid <= keep;
      o_eof   <= keep && s1_eof;
      if (keep) begin
        o_R   <= col_r;
        o_G   <= col_g;
        o_B   <= col_b;
        o_x   <= s1_x;
        o_y   <= s1_y;
        o_hit <= win_hit;
      end
    end
  end

endmodule
